// File: rtl/ula_mdu_pkg.sv
// ula_mdu_pkg: shared constants and types for the multiply/divide unit.
//   ALUOP_RTYPE  : ALUOp code that marks an R-type instruction
//   FUNCT_*      : funct codes for HI/LO moves, multiply and divide
//   mdu_state_t  : iterative MDU FSM states
package ula_mdu_pkg;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/ula_mdu_decode.sv
// mdu_decode: combinational decode of ALUOp/funct into MDU operation classes.
//   en, ALUOp, funct  : instruction in execute stage
//   is_mul / is_div   : MULT/MULTU, DIV/DIVU
//   is_signed         : MULT or DIV (signed variants)
//   is_mf / is_mt     : MFHI/MFLO, MTHI/MTLO
//   sel_hi            : move targets HI (MFHI/MTHI)
module mdu_decode
  import ula_mdu_pkg::*;
(
  input  logic       en,
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic       is_mul,
  output logic       is_div,
  output logic       is_signed,
  output logic       is_mf,
  output logic       is_mt,
  output logic       sel_hi
);

  logic w_rtype;
  assign w_rtype = en & (ALUOp == ALUOP_RTYPE);

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    is_mf     = 1'b0;
    is_mt     = 1'b0;
    sel_hi    = 1'b0;
    if (w_rtype) begin
      case (funct)
        FUNCT_MFHI:  begin is_mf = 1'b1; sel_hi = 1'b1; end
        FUNCT_MTHI:  begin is_mt = 1'b1; sel_hi = 1'b1; end
        FUNCT_MFLO:  is_mf = 1'b1;
        FUNCT_MTLO:  is_mt = 1'b1;
        FUNCT_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
        FUNCT_MULTU: is_mul = 1'b1;
        FUNCT_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
        FUNCT_DIVU:  is_div = 1'b1;
        default:     ;
      endcase
    end
  end

endmodule

// File: rtl/ula_mdu.sv
// ula_mdu: iterative multiply/divide unit with HI/LO registers.
//   clk, rst          : clock, synchronous active-high reset
//   en, ALUOp, funct  : instruction in execute stage
//   rs_val, rt_val    : operands (rs also feeds MTHI/MTLO)
//   result            : MFHI/MFLO read data (0 otherwise)
//   hi, lo            : HI/LO registers
//   busy, stall       : operation in flight / hold the pipeline
//   done, div0        : completion pulse / divide-by-zero pulse
module ula_mdu
  import ula_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t         r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done, r_div0;

  logic w_is_mul, w_is_div, w_is_signed, w_is_mf, w_is_mt, w_sel_hi;
  logic w_md_op, w_accept, w_start, w_last;

  mdu_decode u_decode (
    .en        (en),
    .ALUOp     (ALUOp),
    .funct     (funct),
    .is_mul    (w_is_mul),
    .is_div    (w_is_div),
    .is_signed (w_is_signed),
    .is_mf     (w_is_mf),
    .is_mt     (w_is_mt),
    .sel_hi    (w_sel_hi)
  );

  assign w_md_op  = w_is_mul | w_is_div | w_is_mf | w_is_mt;
  assign busy     = (r_state != MDU_IDLE);
  assign stall    = w_md_op & busy;
  assign w_accept = w_md_op & ~busy;
  assign w_start  = w_accept & (w_is_mul | w_is_div);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  assign hi     = r_hi;
  assign lo     = r_lo;
  assign done   = r_done;
  assign div0   = r_div0;
  assign result = (w_accept & w_is_mf) ? (w_sel_hi ? r_hi : r_lo) : '0;

  // Operand magnitudes for the unsigned iteration core.
  logic             w_rs_neg, w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag, w_rt_mag;
  assign w_rs_neg = w_is_signed & rs_val[WIDTH-1];
  assign w_rt_neg = w_is_signed & rt_val[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_val : rs_val;
  assign w_rt_mag = w_rt_neg ? -rt_val : rt_val;

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: acc = {partial remainder, dividend/quotient bits}.
  // Remainder always stays below the divisor, so WIDTH+1 bits suffice for the trial.
  logic [WIDTH:0]     w_div_shl;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_step;
  assign w_div_shl  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge   = (w_div_shl >= {1'b0, r_a});
  assign w_div_diff = w_div_shl[WIDTH-1:0] - r_a;
  assign w_div_step = {(w_div_ge ? w_div_diff : w_div_shl[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_div_ge};

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) r_state <= MDU_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      MDU_IDLE: if (w_start) w_state_n = w_is_mul ? MDU_MUL : MDU_DIV;
      MDU_MUL:  if (w_last) w_state_n = MDU_FIX;
      MDU_DIV:  if (w_last) w_state_n = MDU_FIX;
      MDU_FIX:  w_state_n = MDU_IDLE;
      default:  w_state_n = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      case (r_state)
        MDU_IDLE: begin
          if (w_start) begin
            r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
            r_a      <= w_rt_mag;
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_dz     <= w_is_div & (rt_val == '0);
          end else if (w_accept & w_is_mt) begin
            if (w_sel_hi) r_hi <= rs_val;
            else          r_lo <= rs_val;
          end
        end
        MDU_MUL: begin
          r_acc <= w_mul_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        MDU_DIV: begin
          r_acc <= w_div_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        MDU_FIX: begin
          // With divisor 0 the remainder path already reproduces rs; only LO is forced.
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= r_dz ? '1 : w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done <= 1'b1;
          r_div0 <= r_is_div & r_dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_mdu.sv
// tb_ula_mdu: directed, table-driven self-checking bench for ula_mdu.
module tb_ula_mdu;
  import ula_mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   ALUOp;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val;
  logic [W-1:0] result, hi, lo;
  logic         busy, stall, done, div0;

  int checks = 0;
  int errors = 0;

  ula_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .ALUOp(ALUOp), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .result(result), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_div0;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present an instruction for one edge; returns at #1 after that edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    en = 1'b1; ALUOp = ALUOP_RTYPE; funct = f; rs_val = a; rt_val = b;
    @(posedge clk); #1;
  endtask

  // Called at the sample point after the accept edge; waits for done.
  task automatic wait_done(output int edges, output int busyc, output int stallc);
    edges = 0; busyc = 0; stallc = 0;
    while (!done && edges < 100) begin
      if (busy)  busyc++;
      if (stall) stallc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  int e, bc, sc;

  initial begin
    vecs[0] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{FUNCT_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3] = '{FUNCT_MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 1'b0};
    vecs[4] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[5] = '{FUNCT_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[6] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7] = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8] = '{FUNCT_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1};
    vecs[9] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

    rst = 1'b1; en = 1'b0; ALUOp = 2'b00; funct = 6'h00; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div0", {31'd0, div0}, 32'd0);

    // Non-MDU funct and non-R-type ALUOp are ignored.
    issue(6'h20, 32'd5, 32'd6);
    check("ignore funct busy", {31'd0, busy}, 32'd0);
    en = 1'b1; ALUOp = 2'b00; funct = FUNCT_MULT;
    @(posedge clk); #1;
    check("ignore aluop busy", {31'd0, busy}, 32'd0);
    en = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      en = 1'b0;
      wait_done(e, bc, sc);
      check($sformatf("v%0d latency", i), e, 33);
      check($sformatf("v%0d busy cycles", i), bc, 33);
      check($sformatf("v%0d done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d lo", i), lo, vecs[i].exp_lo);
      check($sformatf("v%0d div0", i), {31'd0, div0}, {31'd0, vecs[i].exp_div0});
      @(posedge clk); #1;
      check($sformatf("v%0d done pulse", i), {31'd0, done}, 32'd0);
    end

    // MULT followed by MFLO: stalled through busy, reads new LO on done cycle.
    issue(FUNCT_MULT, 32'hFFFFFFFD, 32'd7);
    funct = FUNCT_MFLO;
    check("mflo result while busy", result, '0);
    wait_done(e, bc, sc);
    check("mflo stall cycles", sc, 33);
    check("mflo stall released", {31'd0, stall}, 32'd0);
    check("mflo result", result, 32'hFFFFFFEB);

    // Back-to-back MULTU accepted in the done cycle; HI/LO hold until FIX.
    funct = FUNCT_MULTU; rs_val = 32'd3; rt_val = 32'd5;
    @(posedge clk); #1;
    en = 1'b0;
    check("b2b accepted busy", {31'd0, busy}, 32'd1);
    check("b2b lo held", lo, 32'hFFFFFFEB);
    wait_done(e, bc, sc);
    check("b2b latency", e, 33);
    check("b2b hi", hi, 32'd0);
    check("b2b lo", lo, 32'd15);

    // MTLO queued behind a busy DIVU applies after completion.
    issue(FUNCT_DIVU, 32'd100, 32'd7);
    funct = FUNCT_MTLO; rs_val = 32'hCAFE;
    wait_done(e, bc, sc);
    check("mtlo stalled cycles", sc, 33);
    check("mtlo divu lo", lo, 32'd14);
    @(posedge clk); #1;
    en = 1'b0;
    check("mtlo applied", lo, 32'hCAFE);
    check("mtlo hi unchanged", hi, 32'd2);

    // Reset in the middle of a divide discards it with no done pulse.
    issue(FUNCT_DIV, 32'd1000, 32'd3);
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst hi", hi, '0);
    check("midrst lo", lo, '0);
    check("midrst done", {31'd0, done}, 32'd0);
    bc = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) bc++;
    end
    check("midrst no late done", bc, 0);

    // MTHI then MFHI.
    issue(FUNCT_MTHI, 32'h1234, 32'd0);
    check("mthi hi", hi, 32'h1234);
    check("mthi lo unchanged", lo, '0);
    check("mthi not busy", {31'd0, busy}, 32'd0);
    funct = FUNCT_MFHI; rs_val = 32'd0;
    #1;
    check("mfhi result", result, 32'h1234);
    funct = FUNCT_MFLO;
    #1;
    check("mflo result idle", result, 32'h0);
    en = 1'b0;
    #1;
    check("result when idle", result, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
